// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: walks sequential word addresses and queues {pc, word} for the decoder.
// Latency: an accepted word shows on inst_valid_o/inst_o one cycle after the memory accepts it.
// Backpressure: mem_busy_i holds the address; a full queue drops mem_en_o until the consumer pops.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt_o / fetch_cnt_o performance counters.
module fetch_prefetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_en_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_busy_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] fetch_cnt_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

   state_t          state, state_nxt;
   logic [31:0]     fetch_pc;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic [31:0]     q_pc   [DEPTH];
   logic [31:0]     q_data [DEPTH];
   logic            push, pop;

   // Low address bits of the restart target are dropped by design.
   logic unused_redirect_bits;
   assign unused_redirect_bits = &{1'b0, redirect_pc_i[1:0]};

   assign mem_en_o     = (state == FETCH);
   assign mem_addr_o   = fetch_pc;
   assign inst_valid_o = (count != '0);
   assign inst_o       = inst_valid_o ? q_data[rd_ptr] : 32'h0;
   assign inst_pc_o    = inst_valid_o ? q_pc[rd_ptr]   : 32'h0;

   // Handshakes and next occupancy; a redirect cancels both push and pop.
   always_comb begin
      push      = mem_en_o && !mem_busy_i && !redirect_i;
      pop       = inst_valid_o && inst_ready_i && !redirect_i;
      count_nxt = count + CW'(push) - CW'(pop);
   end

   // Next-state logic; redirect always lands in FETCH.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (count_nxt == FULL_CNT) state_nxt = FULL;
         FULL:    if (pop) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
      if (redirect_i) state_nxt = FETCH;
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Fetch pointer and queue bookkeeping; redirect flushes the queue.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_i) begin
         fetch_pc <= {redirect_pc_i[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            wr_ptr   <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   // Queue storage; contents are qualified by occupancy so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push) begin
         q_pc[wr_ptr]   <= fetch_pc;
         q_data[wr_ptr] <= mem_data_i;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating stall and accepted-fetch counters, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         fetch_cnt_o <= '0;
      end else begin
         if (mem_en_o && mem_busy_i && stall_cnt_o != 32'hFFFF_FFFF)
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if (push && fetch_cnt_o != 32'hFFFF_FFFF)
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch (DEPTH=4, RESET_PC=0).
// Memory returns addr ^ KEY so every queued word is traceable to its pc.
// Vectors: inputs applied at negedge, outputs checked 1 time unit after the next posedge.
module tb_fetch_prefetch;

   localparam logic [31:0] KEY = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst, busy, redir, ready;
   logic [31:0] rpc;
   logic        mem_en, inst_valid;
   logic [31:0] mem_addr, mem_data, inst, inst_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt, fetch_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;
   assign mem_data = mem_addr ^ KEY;

   fetch_prefetch #(.RESET_PC(32'h0), .DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_data_i(mem_data), .mem_busy_i(busy),
      .redirect_i(redir), .redirect_pc_i(rpc),
      .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc), .inst_ready_i(ready)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cnt_o(stall_cnt), .fetch_cnt_o(fetch_cnt)
`endif
   );

   typedef struct {
      logic        rst, busy, ready, redir;
      logic [31:0] rpc;
      logic        en;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic b, input logic rd, input logic rdr,
                       input logic [31:0] p);
      @(negedge clk);
      rst = r; busy = b; ready = rd; redir = rdr; rpc = p;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic en, input logic [31:0] addr,
                          input logic valid, input logic [31:0] pc);
      chk({tag, ".mem_en"}, {31'h0, mem_en}, {31'h0, en});
      chk({tag, ".mem_addr"}, mem_addr, addr);
      chk({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, valid});
      chk({tag, ".inst_pc"}, inst_pc, valid ? pc : 32'h0);
      chk({tag, ".inst"}, inst, valid ? (pc ^ KEY) : 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] s0, f0;
`endif
      //            rst   busy  rdy   redir rpc            en    addr           valid pc
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,         1'b0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,         1'b1, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,         1'b1, 32'h4};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,         1'b0, 32'h0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,         1'b0, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC,         1'b1, 32'h8};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10,        1'b1, 32'h8};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h14,        1'b1, 32'h8};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h18,        1'b1, 32'h8};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h18,        1'b1, 32'h8};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h18,        1'b1, 32'hC};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1C,        1'b1, 32'hC};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1003,     1'b1, 32'h1000,      1'b0, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1004,      1'b1, 32'h1000};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC};
      vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h500,      1'b0, 32'h0,         1'b0, 32'h0};
      vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,         1'b0, 32'h0};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,         1'b1, 32'h0};

      rst = 1'b1; busy = 1'b0; ready = 1'b0; redir = 1'b0; rpc = 32'h0;

      for (int i = 0; i < 23; i++) begin
         step(vecs[i].rst, vecs[i].busy, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
         chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].pc);
      end

      // Simultaneous push and pop at occupancy DEPTH-1 must not fill the queue.
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                 // IDLE -> FETCH
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                 // push 0
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                 // push 4
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                 // push 8, occupancy 3
      chk_out("fill3", 1'b1, 32'hC, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);                 // pop 0 + push C
      chk_out("pushpop", 1'b1, 32'h10, 1'b1, 32'h4);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                 // push 10 -> full
      chk_out("full", 1'b0, 32'h14, 1'b1, 32'h4);
      // Drain in order: 4, 8, C, 10; first pop reopens fetch.
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk_out("drain0", 1'b1, 32'h14, 1'b1, 32'h8);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_out("drain1", 1'b1, 32'h14, 1'b1, 32'hC);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_out("drain2", 1'b1, 32'h14, 1'b1, 32'h10);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_out("drain3", 1'b1, 32'h14, 1'b0, 32'h0);

`ifdef FETCH_PERF_CNT_EN
      // Two busy cycles add exactly two stalls; the following accept adds one fetch.
      s0 = stall_cnt;
      f0 = fetch_cnt;
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall_cnt+2", stall_cnt - s0, 32'd2);
      chk("fetch_cnt_busy", fetch_cnt - f0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("fetch_cnt+1", fetch_cnt - f0, 32'd1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("stall_cnt_rst", stall_cnt, 32'd0);
      chk("fetch_cnt_rst", fetch_cnt, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
